// File: rtl/chargen_pkg.sv
// Shared chargen definitions: FSM state encoding, printable-ASCII ring bounds
// and ring arithmetic helpers. Also imported by the downstream FIFO bench.
package chargen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHAR = 3'd1,
    ST_CR   = 3'd2,
    ST_LF   = 3'd3,
    ST_GAP  = 3'd4
  } chargen_state_t;

  localparam logic [7:0]  CHAR_FIRST = 8'h20;
  localparam logic [7:0]  CHAR_LAST  = 8'h7E;
  localparam int unsigned RING_LEN   = 95;
  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;

  // (s + i) mod RING_LEN by bounded subtraction; s < 95 and i < 255 keep the sum below 3*95+95.
  function automatic logic [7:0] ring_char(input logic [6:0] s, input logic [7:0] i);
    logic [8:0] sum;
    sum = {2'b00, s} + {1'b0, i};
    if (sum >= 9'(3 * RING_LEN))      sum = sum - 9'(3 * RING_LEN);
    else if (sum >= 9'(2 * RING_LEN)) sum = sum - 9'(2 * RING_LEN);
    else if (sum >= 9'(RING_LEN))     sum = sum - 9'(RING_LEN);
    return CHAR_FIRST + 8'(sum);
  endfunction

  function automatic logic [6:0] ring_inc(input logic [6:0] s);
    return (s == 7'(CHAR_LAST - CHAR_FIRST)) ? '0 : s + 7'd1;
  endfunction

endpackage

// File: rtl/chargen_pace.sv
// Loadable down-counter: load wins, otherwise counts down and holds at zero.
// done is high while the count is zero.
module chargen_pace #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/chargen_src.sv
// RFC 864-style character generator with valid/ready output and CDIV pacing.
// Define CHARGEN_CRLF_EN to terminate each line with CR LF.
module chargen_src
  import chargen_pkg::*;
#(
  parameter int unsigned LINE_LEN = 72,
  parameter int unsigned CDIV     = 0,
  parameter int unsigned LCNT_W   = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [LCNT_W-1:0] line_cnt,
  output logic              busy
);

  localparam int unsigned PACE_W    = (CDIV > 0) ? $clog2(CDIV + 1) : 1;
  localparam int unsigned PACE_LOAD = (CDIV > 0) ? CDIV - 1 : 0;
  localparam logic [7:0]  LAST_I    = 8'(LINE_LEN - 1);

  chargen_state_t    state_q, state_d;
  chargen_state_t    pend_q, pend_d;
  logic [6:0]        s_q, s_d;
  logic [7:0]        i_q, i_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic              busy_q, busy_d;
  logic              xfer, present, pace_load, pace_done;

  assign xfer = tx_valid_q && tx_ready;

  // Loaded with CDIV-1 so that exactly CDIV idle cycles separate two bytes.
  chargen_pace #(.W(PACE_W)) u_pace (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (pace_load),
    .load_val (PACE_W'(PACE_LOAD)),
    .done     (pace_done)
  );

  // pend tracks which byte kind goes out next, so pausing in GAP or IDLE resumes exactly.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    s_d        = s_q;
    i_d        = i_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    line_cnt_d = line_cnt_q;
    pace_load  = 1'b0;
    present    = 1'b0;

    case (state_q)
      ST_IDLE: present = en;
      ST_GAP: begin
        if (pace_done) begin
          if (en) present = 1'b1;
          else    state_d = ST_IDLE;
        end
      end
      default: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (state_q == ST_CHAR) begin
            if (i_q == LAST_I) begin
              i_d = '0;
`ifdef CHARGEN_CRLF_EN
              pend_d = ST_CR;
`else
              s_d        = ring_inc(s_q);
              line_cnt_d = line_cnt_q + LCNT_W'(1);
`endif
            end else begin
              i_d = i_q + 8'd1;
            end
          end
`ifdef CHARGEN_CRLF_EN
          else if (state_q == ST_CR) begin
            pend_d = ST_LF;
          end else begin
            pend_d     = ST_CHAR;
            s_d        = ring_inc(s_q);
            line_cnt_d = line_cnt_q + LCNT_W'(1);
          end
`endif
          if (CDIV == 0) begin
            if (en) present = 1'b1;
            else    state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            pace_load = 1'b1;
          end
        end
      end
    endcase

    if (present) begin
      state_d    = pend_d;
      tx_valid_d = 1'b1;
      case (pend_d)
        ST_CR:   tx_data_d = ASCII_CR;
        ST_LF:   tx_data_d = ASCII_LF;
        default: tx_data_d = ring_char(s_d, i_d);
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= ST_CHAR;
      s_q        <= '0;
      i_q        <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      line_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      s_q        <= s_d;
      i_q        <= i_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      line_cnt_q <= line_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign line_cnt = line_cnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_chargen_src.sv
// Scoreboard bench for chargen_src: instance A (LINE_LEN=4, CDIV=0) and
// instance B (LINE_LEN=1, CDIV=3). Honours CHARGEN_CRLF_EN when defined.
module tb_chargen_src;

`ifdef CHARGEN_CRLF_EN
  localparam int unsigned A_WIRE = 6;
  localparam int unsigned B_WIRE = 3;
`else
  localparam int unsigned A_WIRE = 4;
  localparam int unsigned B_WIRE = 1;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        a_en = 1'b0, a_ready = 1'b0, a_valid, a_busy;
  logic [7:0]  a_data;
  logic [15:0] a_lcnt;
  logic        b_en = 1'b0, b_ready = 1'b0, b_valid, b_busy;
  logic [7:0]  b_data;
  logic [15:0] b_lcnt;

  int unsigned chk = 0;
  int unsigned err = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [7:0]  b_seen[$];
  int unsigned ms, mi;
  logic [7:0]  hold_exp;

  chargen_src #(.LINE_LEN(4), .CDIV(0), .LCNT_W(16)) u_a (
    .clk(clk), .n_rst(n_rst), .en(a_en), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .line_cnt(a_lcnt), .busy(a_busy)
  );

  chargen_src #(.LINE_LEN(1), .CDIV(3), .LCNT_W(16)) u_b (
    .clk(clk), .n_rst(n_rst), .en(b_en), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .line_cnt(b_lcnt), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int unsigned s, input int unsigned i);
`ifdef CHARGEN_CRLF_EN
    if (i == 4) return 8'h0D;
    if (i == 5) return 8'h0A;
`endif
    return 8'(32'h20 + (s + i) % 95);
  endfunction

  task automatic push_model_a(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      qa.push_back(model_byte(ms, mi));
      mi++;
      if (mi == A_WIRE) begin
        mi = 0;
        ms = (ms + 1) % 95;
      end
    end
  endtask

  task automatic drain_a(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (qa.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, qa.size(), 0);
    qa.delete();
  endtask

  // Transfers complete on the next posedge when valid && ready at the negedge.
  always @(negedge clk) begin
    if (n_rst && a_valid && a_ready) begin
      if (qa.size() == 0) begin
        chk++; err++;
        $display("FAIL a_unexpected_byte: got %0h expected none", a_data);
      end else check("a_byte", a_data, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (n_rst && b_valid && b_ready) begin
      b_seen.push_back(b_data);
      if (qb.size() == 0) begin
        chk++; err++;
        $display("FAIL b_unexpected_byte: got %0h expected none", b_data);
      end else check("b_byte", b_data, qb.pop_front());
    end
  end

  initial begin
    logic [7:0] b2b[8];
    logic [7:0] res[4];
    int unsigned n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 0);
    check("rst_lcnt", a_lcnt, 0);
    check("rst_busy", a_busy, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", a_valid, 0);

`ifdef CHARGEN_CRLF_EN
    b2b = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h0D, 8'h0A, 8'h21, 8'h22};
`else
    b2b = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h21, 8'h22, 8'h23, 8'h24};
`endif
    foreach (b2b[k]) qa.push_back(b2b[k]);
    a_ready = 1'b1;
    a_en = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_valid", a_valid, 1);
    check("b2b_busy", a_busy, 1);
    repeat (7) @(posedge clk);
    #1 a_en = 1'b0;
    @(posedge clk); #1;
    check("b2b_stop_valid", a_valid, 0);
    check("b2b_stop_busy", a_busy, 0);
`ifdef CHARGEN_CRLF_EN
    check("b2b_lcnt", a_lcnt, 1);
    ms = 1; mi = 2;
`else
    check("b2b_lcnt", a_lcnt, 2);
    ms = 2; mi = 0;
`endif
    drain_a("b2b_drain", 4);

    hold_exp = model_byte(ms, mi);
    push_model_a(200);
    a_ready = 1'b0;
    a_en = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid", a_valid, 1);
      check("bp_hold_data", a_data, hold_exp);
    end
    n = 0;
    while (qa.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      a_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    a_ready = 1'b0;
    check("bp_drain", qa.size(), 0);
    qa.delete();
`ifdef CHARGEN_CRLF_EN
    check("bp_lcnt", a_lcnt, 34);
`else
    check("bp_lcnt", a_lcnt, 52);
`endif

    @(posedge clk); #2;
    check("pre_rst_valid", a_valid, 1);
    n_rst = 1'b0;
    #1;
    check("arst_valid", a_valid, 0);
    check("arst_lcnt", a_lcnt, 0);
    check("arst_busy", a_busy, 0);
    a_en = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;

    qa.push_back(8'h20);
    a_ready = 1'b1;
    a_en = 1'b1;
    @(posedge clk); #1;
    a_en = 1'b0;
    @(posedge clk); #1;
    check("pause_valid", a_valid, 0);
    drain_a("restart_drain", 4);
    repeat (3) @(posedge clk);
    #1;
    check("pause_busy", a_busy, 0);

`ifdef CHARGEN_CRLF_EN
    res = '{8'h21, 8'h22, 8'h23, 8'h0D};
`else
    res = '{8'h21, 8'h22, 8'h23, 8'h21};
`endif
    foreach (res[k]) qa.push_back(res[k]);
    a_en = 1'b1;
    repeat (4) @(posedge clk);
    #1 a_en = 1'b0;
    @(posedge clk); #1;
    check("resume_valid", a_valid, 0);
`ifdef CHARGEN_CRLF_EN
    check("resume_lcnt", a_lcnt, 0);
`else
    check("resume_lcnt", a_lcnt, 1);
`endif
    drain_a("resume_drain", 4);

    for (int unsigned ln = 0; ln < 96; ln++) begin
      qb.push_back(8'(32'h20 + ln % 95));
`ifdef CHARGEN_CRLF_EN
      qb.push_back(8'h0D);
      qb.push_back(8'h0A);
`endif
    end
    b_ready = 1'b1;
    b_en = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("b_pace_valid", b_valid, (k % 4 == 0) ? 1 : 0);
    end
    n = 0;
    while (qb.size() != 0 && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    b_en = 1'b0;
    check("b_drain", qb.size(), 0);
    repeat (6) @(posedge clk);
    #1;
    check("b_idle_valid", b_valid, 0);
    check("b_lcnt", b_lcnt, 96);
    check("b_line95_first", (b_seen.size() > 94 * B_WIRE) ? b_seen[94 * B_WIRE] : 8'h00, 8'h7E);
    check("b_line96_first", (b_seen.size() > 95 * B_WIRE) ? b_seen[95 * B_WIRE] : 8'h00, 8'h20);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #1000000;
    err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
